// File: rtl/io_uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package io_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int         FRAME_BITS     = 10;
  localparam logic [7:0] IO_TX_ADDR     = 8'hFF;
  localparam logic [7:0] IO_STATUS_ADDR = 8'hFE;

  localparam int STAT_BUSY = 0;
  localparam int STAT_FULL = 1;
  localparam int STAT_OVF  = 2;
endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module io_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/io_uart_tx.sv
// Store-to-0xFF UART transmitter: each queued word goes out as two 8N1 frames,
// low byte first, with consecutive frames and words abutting on the line.
module io_uart_tx
  import io_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  output logic        tx,
  output logic        busy,
  output logic        full,
  output logic [15:0] status
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  tx_state_t   state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q;
  logic        byte_sel_q;
  logic [15:0] shift_q;
  logic        tx_q;
  logic        ovf_q;

  logic        empty, pop, bit_end, cur_bit;
  logic [15:0] head;
  logic [7:0]  cur_byte;

  io_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_en),
    .pop   (pop),
    .din   (wr_data),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign bit_end  = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign cnt_d    = bit_end ? '0 : cnt_q + CW'(1);
  assign cur_byte = byte_sel_q ? shift_q[15:8] : shift_q[7:0];
  assign cur_bit  = cur_byte[bit_idx_q];
  // Next word is pulled either from idle or right as the high byte's stop bit ends.
  assign pop      = !empty && ((state_q == IDLE) ||
                               (state_q == STOP && bit_end && byte_sel_q));

  assign tx   = tx_q;
  assign busy = (state_q != IDLE) || !empty;

  always_comb begin
    status            = '0;
    status[STAT_BUSY] = busy;
    status[STAT_FULL] = full;
    status[STAT_OVF]  = ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      byte_sel_q <= 1'b0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      if (wr_en && full) ovf_q <= 1'b1;
      // Line level follows the state one cycle later.
      tx_q <= (state_q == START) ? 1'b0 : (state_q == DATA) ? cur_bit : 1'b1;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!empty) begin
            state_q    <= START;
            shift_q    <= head;
            byte_sel_q <= 1'b0;
          end
        end
        START: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            state_q   <= DATA;
            bit_idx_q <= '0;
          end
        end
        DATA: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            if (bit_idx_q == 3'd7) state_q <= STOP;
            else                   bit_idx_q <= bit_idx_q + 3'd1;
          end
        end
        STOP: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            if (!byte_sel_q) begin
              byte_sel_q <= 1'b1;
              state_q    <= START;
            end else if (!empty) begin
              shift_q    <= head;
              byte_sel_q <= 1'b0;
              state_q    <= START;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx with a reference line receiver decoding tx.
module tb_io_uart_tx;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        tx, busy, full;
  logic [15:0] status;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] rx_q[$];
  int         rx_t[$];
  logic [7:0] exp_q[$];
  logic [7:0] mb;
  int         mts;

  io_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .tx      (tx),
    .busy    (busy),
    .full    (full),
    .status  (status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Reference receiver: detect start, sample each bit in its third cycle.
  always begin
    @(posedge clk); #1;
    if (rst_n === 1'b1 && tx === 1'b0) begin
      mts = cyc;
      repeat (2) @(posedge clk); #1;
      chk("start_mid", {31'd0, tx}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clk); #1;
        mb[i] = tx;
      end
      repeat (CPB) @(posedge clk); #1;
      chk("stop_bit", {31'd0, tx}, 32'd1);
      rx_q.push_back(mb);
      rx_t.push_back(mts);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [15:0] d);
    wr_en = 1'b1;
    wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic exp_word(input logic [15:0] w);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 3000) begin
      step();
      n++;
    end
    chk("idle_timeout", {31'd0, n < 3000}, 32'd1);
    repeat (10) step();
  endtask

  // Compare received bytes and require every frame start exactly 10 bit-times apart.
  task automatic check_rx();
    chk("rx_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      chk("rx_byte", {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    for (int i = 1; i < rx_t.size(); i++)
      chk("frame_gap", rx_t[i] - rx_t[i-1], 10 * CPB);
    rx_q.delete();
    rx_t.delete();
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    wr_data = '0;
    repeat (3) step();
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_status", {16'd0, status}, 32'h0);
    rst_n = 1'b1;
    repeat (10) step();
    chk("idle_tx", {31'd0, tx}, 32'd1);
    chk("idle_status", {16'd0, status}, 32'h0);

    // Single word: latency, content, busy fall point.
    wr(16'hA55A);
    step();
    chk("lat_n1", {31'd0, tx}, 32'd1);
    step();
    chk("lat_n2", {31'd0, tx}, 32'd0);
    chk("busy_run", {31'd0, busy}, 32'd1);
    repeat (78) step();
    chk("busy_last", {31'd0, busy}, 32'd1);
    step();
    chk("busy_drop", {31'd0, busy}, 32'd0);
    exp_word(16'hA55A);
    wait_idle();
    chk("tx_high", {31'd0, tx}, 32'd1);
    check_rx();

    // Burst of six: first pops immediately, 2..5 fill, 6 overflows.
    for (int k = 1; k <= 6; k++) begin
      wr(16'(k));
      if (k == 4) chk("full_k4", {31'd0, full}, 32'd0);
      if (k == 5) chk("full_k5", {31'd0, full}, 32'd1);
      if (k == 6) chk("status_ovf", {16'd0, status}, 32'h7);
    end
    for (int k = 1; k <= 5; k++) exp_word(16'(k));
    wait_idle();
    chk("ovf_sticky", {16'd0, status}, 32'h4);
    check_rx();

    // Two words back to back.
    wr(16'h0F0F);
    wr(16'hF00F);
    exp_word(16'h0F0F);
    exp_word(16'hF00F);
    wait_idle();
    check_rx();

    // Reset mid high-byte data bit 0.
    wr(16'h1234);
    repeat (46) step();
    chk("pre_rst_tx", {31'd0, tx}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_tx", {31'd0, tx}, 32'd1);
    chk("async_status", {16'd0, status}, 32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (50) step();
    chk("post_rst_status", {16'd0, status}, 32'h0);
    rx_q.delete();
    rx_t.delete();
    wr(16'hC3E1);
    exp_word(16'hC3E1);
    wait_idle();
    check_rx();

    // Write while full in the same cycle as a pop.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("clr_status", {16'd0, status}, 32'h0);
    for (int k = 1; k <= 5; k++) wr(16'hB000 | 16'(k));
    chk("full_pre", {31'd0, full}, 32'd1);
    repeat (76) step();
    chk("pre_pop_status", {16'd0, status}, 32'h3);
    wr(16'hDEAD);
    chk("pop_ovf_status", {16'd0, status}, 32'h5);
    for (int k = 1; k <= 5; k++) exp_word(16'hB000 | 16'(k));
    wait_idle();
    check_rx();
    chk("final_status", {16'd0, status}, 32'h4);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
